// File: rtl/nf10_axis_tx_arbiter.sv
// Packet-granular round-robin arbiter: four AXI4-Stream requesters onto one 10G TX port.
// Optional per-port packet counters are built when ARB_PKT_CNT_EN is defined.
module nf10_axis_tx_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic                            s0_axis_tvalid,
  input  logic                            s0_axis_tlast,
  output logic                            s0_axis_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic                            s1_axis_tvalid,
  input  logic                            s1_axis_tlast,
  output logic                            s1_axis_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s2_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s2_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s2_axis_tuser,
  input  logic                            s2_axis_tvalid,
  input  logic                            s2_axis_tlast,
  output logic                            s2_axis_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s3_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s3_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s3_axis_tuser,
  input  logic                            s3_axis_tvalid,
  input  logic                            s3_axis_tlast,
  output logic                            s3_axis_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,

  output logic [1:0]                      grant,
  output logic                            busy
`ifdef ARB_PKT_CNT_EN
  ,
  input  logic                            pkt_cnt_clear,
  output logic [31:0]                     pkt_cnt0,
  output logic [31:0]                     pkt_cnt1,
  output logic [31:0]                     pkt_cnt2,
  output logic [31:0]                     pkt_cnt3
`endif
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;

  logic [DW-1:0] tdata_a [4];
  logic [SW-1:0] tstrb_a [4];
  logic [UW-1:0] tuser_a [4];
  logic [3:0]    req;
  logic [3:0]    tlast_a;
  logic [1:0]    start;
  logic [2:0]    pick;
  logic          eop;

  assign tdata_a[0] = s0_axis_tdata;
  assign tdata_a[1] = s1_axis_tdata;
  assign tdata_a[2] = s2_axis_tdata;
  assign tdata_a[3] = s3_axis_tdata;

  assign tstrb_a[0] = s0_axis_tstrb;
  assign tstrb_a[1] = s1_axis_tstrb;
  assign tstrb_a[2] = s2_axis_tstrb;
  assign tstrb_a[3] = s3_axis_tstrb;

  assign tuser_a[0] = s0_axis_tuser;
  assign tuser_a[1] = s1_axis_tuser;
  assign tuser_a[2] = s2_axis_tuser;
  assign tuser_a[3] = s3_axis_tuser;

  assign req = {s3_axis_tvalid, s2_axis_tvalid,
                s1_axis_tvalid, s0_axis_tvalid};

  assign tlast_a = {s3_axis_tlast, s2_axis_tlast,
                    s1_axis_tlast, s0_axis_tlast};

  // First requester at or after start; returns {found, index}.
  function automatic logic [2:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] s
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = s + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign busy  = (state_q == BUSY);
  assign grant = grant_q;

  assign m_axis_tdata  = tdata_a[grant_q];
  assign m_axis_tstrb  = tstrb_a[grant_q];
  assign m_axis_tuser  = tuser_a[grant_q];
  assign m_axis_tlast  = tlast_a[grant_q];
  assign m_axis_tvalid = busy & req[grant_q];

  assign s0_axis_tready = busy & (grant_q == 2'd0) & m_axis_tready;
  assign s1_axis_tready = busy & (grant_q == 2'd1) & m_axis_tready;
  assign s2_axis_tready = busy & (grant_q == 2'd2) & m_axis_tready;
  assign s3_axis_tready = busy & (grant_q == 2'd3) & m_axis_tready;

  assign eop = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Searching from grant+1 puts grant last, so it only wins when alone.
  assign start = busy ? grant_q + 2'd1 : last_q + 2'd1;
  assign pick  = rr_pick(req, start);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick[2]) begin
          grant_d = pick[1:0];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (eop) begin
          last_d = grant_q;
          if (pick[2]) grant_d = pick[1:0];
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_PKT_CNT_EN
  logic [31:0] cnt_q [4];

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (pkt_cnt_clear) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (eop) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
    end
  end

  assign pkt_cnt0 = cnt_q[0];
  assign pkt_cnt1 = cnt_q[1];
  assign pkt_cnt2 = cnt_q[2];
  assign pkt_cnt3 = cnt_q[3];
`endif

endmodule
